depth_xds_tx: RTL and testbench
===============================

# depth_xds_tx

Frame source for the depth XDS stream. On a start pulse it reads a W×H depth image row-major from a single-port depth SRAM (CEN/WEN active-low, 1-cycle read latency) and transmits it pixel by pixel over the XDS valid/ready interface. It brackets each frame with one-cycle frame-start and frame-finish pulses. It is the transmitting end for the depth-histogram block's `i_DEPTH_XDS_IN_VALID` / `o_DEPTH_XDS_IN_READY` / `i_DEPTH` input and is used both in the bench and for replaying stored frames.

## Interface
- p_depth_bit, 8, depth pixel width (= SRAM data width)
- p_addr_bit, 14, depth SRAM address width
- p_dim_bit, 8, width of i_WIDTH / i_HEIGHT
- i_CLK  in  1  clock, all logic on rising edge
- i_RST  in  1  synchronous, active-high reset
- i_WIDTH  in  p_dim_bit  pixels per row, sampled at frame start
- i_HEIGHT  in  p_dim_bit  rows per frame, sampled at frame start
- i_START  in  1  frame request; honoured only in IDLE
- o_BUSY  out  1  high from START state through FINISH state
- o_FRAME_START  out  1  one-cycle pulse, first cycle of a frame
- o_FRAME_FINISH  out  1  one-cycle pulse, after last pixel handshake
- o_DEPTH_XDS_VALID  out  1  o_DEPTH holds a valid pixel
- i_DEPTH_XDS_READY  in  1  sink accepts pixel when high with VALID
- o_DEPTH  out  p_depth_bit  pixel data
- o_SRAM_CEN  out  1  active-low chip enable; 0 only on issued reads
- o_SRAM_WEN  out  1  tied 1 (read-only)
- o_SRAM_A  out  p_addr_bit  read address
- i_SRAM_Q  in  p_depth_bit  read data, valid the cycle after the address

## Operation
- FSM states:
  - IDLE --i_START--> START
  - START --> STREAM if W·H>0, else FINISH
  - STREAM --> FINISH on the handshake of pixel N−1
  - FINISH --> IDLE
- START: latch W, H; compute N = W·H (2·p_dim_bit bits); o_FRAME_START=1.
- Read issue counter rd_cnt (2·p_dim_bit bits):
  - o_SRAM_A = rd_cnt[p_addr_bit−1:0]; addresses wrap modulo 2^p_addr_bit when N > 2^p_addr_bit.
  - Reads are issued from START (address 0) while rd_cnt < N and credit is available.
- Output buffer: 2-entry FIFO plus a 1-bit in-flight flag. A read is issued in cycle t iff fifo_count + inflight − pop_t < 2, where pop_t = VALID & READY in cycle t. This sustains 1 pixel/cycle under continuous READY, and no data is ever dropped under backpressure.
- i_SRAM_Q is pushed into the FIFO in the cycle after the read is issued.
- o_DEPTH_XDS_VALID = FIFO non-empty. o_DEPTH = FIFO head.
- Handshake rules:
  - Once VALID is high it stays high with o_DEPTH stable until accepted.
  - VALID never depends combinationally on READY.
- Send counter tx_cnt counts handshakes; handshake with tx_cnt = N−1 moves the FSM to FINISH.
- FINISH: o_FRAME_FINISH=1; FIFO is empty and no read is in flight.
- i_START in any state other than IDLE is ignored; no queuing.
- i_WIDTH / i_HEIGHT changes after START have no effect on the current frame.

## Timing
- Reset values (cycle after i_RST high):
  - o_BUSY=0, o_FRAME_START=0, o_FRAME_FINISH=0, o_DEPTH_XDS_VALID=0
  - o_DEPTH=0, o_SRAM_CEN=1, o_SRAM_A=0, o_SRAM_WEN=1
  - FIFO empty, in-flight cleared, FSM=IDLE
- Reset mid-frame: aborts immediately, no FRAME_FINISH; a read in flight is discarded.
- Frame sequence, with i_START high in cycle 0 and READY held high:
  - Cycle 1: FRAME_START=1, BUSY=1, CEN=0, A=0.
  - Cycle 2: Q=mem[0] pushed.
  - Cycle 3: VALID=1, o_DEPTH=mem[0].
  - Pixel k is accepted in cycle 3+k; the last pixel is accepted in cycle 2+N.
  - Cycle 3+N: FRAME_FINISH=1.
  - Cycle 4+N: BUSY=0; i_START is honoured in this cycle.
- Zero-size frame (W=0 or H=0): cycle 1 START, cycle 2 FRAME_FINISH, cycle 3 IDLE; no CEN=0, no VALID.
- FRAME_START always precedes the first VALID by 2 cycles. FRAME_FINISH is never coincident with VALID.
- READY deasserted: at most 2 pixels are buffered and reads stop. When READY returns, data resumes the next cycle with no bubble beyond SRAM latency.

## Test plan
- Preload mem[i]=i&0xFF; W=4, H=3, READY=1 → pixels 0..11 accepted in cycles 3..14, FRAME_FINISH in cycle 15, exactly 12 CEN=0 cycles.
- Same frame, READY toggling 1/0 every cycle → same 12-value ordered sequence, o_DEPTH stable while VALID&!READY, never more than 2 reads outstanding beyond accepted count.
- W=0, H=5 → FRAME_START cycle 1, FRAME_FINISH cycle 2, VALID never high, CEN never low.
- i_START pulsed in cycles 0 and 5 of a W=8,H=8 frame → second pulse ignored, one frame of 64 pixels, one FRAME_FINISH.
- i_RST high at pixel 20 of a W=16,H=16 frame → next cycle all outputs at reset values; new start then sends pixel 0 = mem[0] correctly.
- p_addr_bit=4, W=5, H=4 → pixel 16 equals mem[0] (address wrap), 20 pixels total.

Source files
------------

// File: rtl/depth_xds_tx_if.sv
// XDS valid/ready stream plus depth SRAM read port
// for the depth frame source.
interface depth_xds_tx_if #(
  parameter int p_depth_bit = 8,
  parameter int p_addr_bit  = 14
);
  logic                   o_DEPTH_XDS_VALID;
  logic                   i_DEPTH_XDS_READY;
  logic [p_depth_bit-1:0] o_DEPTH;
  logic                   o_SRAM_CEN;
  logic                   o_SRAM_WEN;
  logic [p_addr_bit-1:0]  o_SRAM_A;
  logic [p_depth_bit-1:0] i_SRAM_Q;

  modport master (
    output o_DEPTH_XDS_VALID,
    output o_DEPTH,
    output o_SRAM_CEN,
    output o_SRAM_WEN,
    output o_SRAM_A,
    input  i_DEPTH_XDS_READY,
    input  i_SRAM_Q
  );

  modport slave (
    input  o_DEPTH_XDS_VALID,
    input  o_DEPTH,
    input  o_SRAM_CEN,
    input  o_SRAM_WEN,
    input  o_SRAM_A,
    output i_DEPTH_XDS_READY,
    output i_SRAM_Q
  );
endinterface

// File: rtl/depth_xds_tx.sv
// Depth frame source: reads a WxH image from SRAM
// and streams it over XDS valid/ready.
module depth_xds_tx #(
  parameter int p_depth_bit = 8,
  parameter int p_addr_bit  = 14,
  parameter int p_dim_bit   = 8
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic [p_dim_bit-1:0] i_WIDTH,
  input  logic [p_dim_bit-1:0] i_HEIGHT,
  input  logic                 i_START,
  output logic                 o_BUSY,
  output logic                 o_FRAME_START,
  output logic                 o_FRAME_FINISH,
  depth_xds_tx_if.master       xds
);
  localparam int CW = 2 * p_dim_bit;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [p_dim_bit-1:0]   r_w;
  logic [p_dim_bit-1:0]   r_h;
  logic [CW-1:0]          w_n;
  logic [CW-1:0]          r_rd_cnt;
  logic [CW-1:0]          r_tx_cnt;
  logic [p_depth_bit-1:0] r_fifo [2];
  logic                   r_wp;
  logic                   r_rp;
  logic [1:0]             r_cnt;
  logic                   r_inflight;

  logic       w_valid;
  logic       w_pop;
  logic [2:0] w_occ;
  logic       w_rd;
  logic       w_last;
  logic       w_active;

  assign w_n     = CW'(r_w) * CW'(r_h);
  assign w_valid = (r_cnt != 2'd0);
  assign w_pop   = w_valid & xds.i_DEPTH_XDS_READY;

  // Buffered + in-flight words after this cycle's pop;
  // a new read needs a free slot to land in.
  assign w_occ = {1'b0, r_cnt}
               + {2'b0, r_inflight}
               - {2'b0, w_pop};

  assign w_active = (r_state == S_START)
                  | (r_state == S_STREAM);
  assign w_rd     = w_active
                  & (r_rd_cnt < w_n)
                  & (w_occ < 3'd2);
  assign w_last   = w_pop & (r_tx_cnt == w_n - 1'b1);

  assign xds.o_DEPTH_XDS_VALID = w_valid;
  assign xds.o_DEPTH           = r_fifo[r_rp];
  assign xds.o_SRAM_CEN        = ~w_rd;
  assign xds.o_SRAM_WEN        = 1'b1;
  assign xds.o_SRAM_A          = r_rd_cnt[p_addr_bit-1:0];

  always_comb begin
    w_next         = r_state;
    o_BUSY         = 1'b1;
    o_FRAME_START  = 1'b0;
    o_FRAME_FINISH = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_BUSY = 1'b0;
        if (i_START) w_next = S_START;
      end
      S_START: begin
        o_FRAME_START = 1'b1;
        w_next = (w_n != '0) ? S_STREAM : S_FINISH;
      end
      S_STREAM: begin
        if (w_last) w_next = S_FINISH;
      end
      S_FINISH: begin
        o_FRAME_FINISH = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state    <= S_IDLE;
      r_w        <= '0;
      r_h        <= '0;
      r_rd_cnt   <= '0;
      r_tx_cnt   <= '0;
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_cnt      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_rd;
      if (r_state == S_IDLE && i_START) begin
        r_w      <= i_WIDTH;
        r_h      <= i_HEIGHT;
        r_rd_cnt <= '0;
        r_tx_cnt <= '0;
      end
      if (w_rd) r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_pop) begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
        r_rp     <= ~r_rp;
      end
      if (r_inflight) begin
        r_fifo[r_wp] <= xds.i_SRAM_Q;
        r_wp         <= ~r_wp;
      end
      r_cnt <= r_cnt
             + {1'b0, r_inflight}
             - {1'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_depth_xds_tx.sv
// Directed bench for depth_xds_tx: frame table,
// mid-frame reset and address-wrap sequences.
module tb_depth_xds_tx;
  localparam int DB  = 8;
  localparam int AB  = 14;
  localparam int AB2 = 4;
  localparam int DM  = 8;

  typedef struct {
    int w;
    int h;
    int mode;
    int n;
    int first;
    int stp;
    int ff;
    int again;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DM-1:0] w, h, w2, h2;
  logic st, st2;
  logic busy, fs, ff;
  logic busy2, fs2, ff2;

  depth_xds_tx_if #(.p_depth_bit(DB), .p_addr_bit(AB))  xi ();
  depth_xds_tx_if #(.p_depth_bit(DB), .p_addr_bit(AB2)) xi2 ();

  depth_xds_tx #(
    .p_depth_bit(DB), .p_addr_bit(AB), .p_dim_bit(DM)
  ) u_dut (
    .i_CLK(clk), .i_RST(rst),
    .i_WIDTH(w), .i_HEIGHT(h), .i_START(st),
    .o_BUSY(busy), .o_FRAME_START(fs),
    .o_FRAME_FINISH(ff), .xds(xi)
  );

  depth_xds_tx #(
    .p_depth_bit(DB), .p_addr_bit(AB2), .p_dim_bit(DM)
  ) u_wrap (
    .i_CLK(clk), .i_RST(rst),
    .i_WIDTH(w2), .i_HEIGHT(h2), .i_START(st2),
    .o_BUSY(busy2), .o_FRAME_START(fs2),
    .o_FRAME_FINISH(ff2), .xds(xi2)
  );

  // SRAM models: mem[a] = a & 0xFF, mem2[a] = 0x80 | a
  always @(posedge clk) begin
    if (!xi.o_SRAM_CEN)
      xi.i_SRAM_Q <= xi.o_SRAM_A[7:0];
    if (!xi2.o_SRAM_CEN)
      xi2.i_SRAM_Q <= {4'h8, xi2.o_SRAM_A};
  end

  int q_pix[$], q_cyc[$], q_pix2[$];
  int fs_n = 0, fs_cyc = 0, ff_n = 0, ff_cyc = 0;
  int cen_n = 0, vld_n = 0, ff2_n = 0;
  int stall_bad = 0, out_bad = 0, ffv_bad = 0;
  int rd_n = 0, acc_n = 0, prev_d = 0;
  bit prev_stall = 0;

  always @(negedge clk) begin
    if (rst) begin
      rd_n = acc_n;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        if (!xi.o_DEPTH_XDS_VALID
            || int'(xi.o_DEPTH) != prev_d)
          stall_bad++;
      end
      prev_stall = xi.o_DEPTH_XDS_VALID
                 && !xi.i_DEPTH_XDS_READY;
      prev_d = int'(xi.o_DEPTH);
      if (xi.o_DEPTH_XDS_VALID) vld_n++;
      if (xi.o_DEPTH_XDS_VALID && xi.i_DEPTH_XDS_READY) begin
        q_pix.push_back(int'(xi.o_DEPTH));
        q_cyc.push_back(cyc);
        acc_n++;
      end
      if (!xi.o_SRAM_CEN) begin
        cen_n++;
        rd_n++;
        if (rd_n - acc_n > 2) out_bad++;
      end
      if (fs) begin fs_n++; fs_cyc = cyc; end
      if (ff) begin
        ff_n++;
        ff_cyc = cyc;
        if (xi.o_DEPTH_XDS_VALID) ffv_bad++;
      end
      if (xi2.o_DEPTH_XDS_VALID && xi2.i_DEPTH_XDS_READY)
        q_pix2.push_back(int'(xi2.o_DEPTH));
      if (ff2) ff2_n++;
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_fs"}, int'(fs), 0);
    chk({tag, "_ff"}, int'(ff), 0);
    chk({tag, "_valid"}, int'(xi.o_DEPTH_XDS_VALID), 0);
    chk({tag, "_depth"}, int'(xi.o_DEPTH), 0);
    chk({tag, "_cen"}, int'(xi.o_SRAM_CEN), 1);
    chk({tag, "_addr"}, int'(xi.o_SRAM_A), 0);
    chk({tag, "_wen"}, int'(xi.o_SRAM_WEN), 1);
  endtask

  task automatic do_frame(input vec_t v);
    int t0, pb, fsb, ffb, cb, vb, sb, ob, fb, to;
    pb = q_pix.size();
    fsb = fs_n; ffb = ff_n; cb = cen_n;
    vb = vld_n; sb = stall_bad; ob = out_bad;
    fb = ffv_bad;
    w = DM'(v.w);
    h = DM'(v.h);
    st = 1'b1;
    t0 = cyc;
    xi.i_DEPTH_XDS_READY = 1'b1;
    step();
    st = 1'b0;
    w = '1;
    h = '1;
    to = 1;
    for (int i = 0; i < 3000; i++) begin
      xi.i_DEPTH_XDS_READY = (v.mode == 0)
                          || ((cyc - t0) % 2 == 0);
      st = (v.again >= 0 && cyc == t0 + v.again);
      if (!busy) begin
        to = 0;
        break;
      end
      step();
    end
    xi.i_DEPTH_XDS_READY = 1'b1;
    st = 1'b0;
    chk("timeout", to, 0);
    chk("idle_cyc", cyc - t0, v.ff + 1);
    chk("fs_n", fs_n - fsb, 1);
    chk("fs_cyc", fs_cyc - t0, 1);
    chk("ff_n", ff_n - ffb, 1);
    chk("ff_cyc", ff_cyc - t0, v.ff);
    chk("npix", q_pix.size() - pb, v.n);
    chk("cen_n", cen_n - cb, v.n);
    chk("stall", stall_bad - sb, 0);
    chk("outstanding", out_bad - ob, 0);
    chk("ff_vs_valid", ffv_bad - fb, 0);
    if (v.n == 0) chk("valid_n", vld_n - vb, 0);
    for (int k = 0; k < v.n; k++) begin
      if (pb + k < q_pix.size()) begin
        chk($sformatf("pix%0d", k), q_pix[pb + k], k & 255);
        chk($sformatf("pcyc%0d", k),
            q_cyc[pb + k] - t0, v.first + v.stp * k);
      end
    end
  endtask

  vec_t tbl[7];

  initial begin
    int ffb, pb, to;
    tbl[0] = '{4, 3, 0, 12, 3, 1, 15, -1};
    tbl[1] = '{4, 3, 1, 12, 4, 2, 27, -1};
    tbl[2] = '{0, 5, 0, 0, 0, 0, 2, -1};
    tbl[3] = '{1, 1, 0, 1, 3, 1, 4, -1};
    tbl[4] = '{7, 2, 0, 14, 3, 1, 17, -1};
    tbl[5] = '{3, 1, 1, 3, 4, 2, 9, -1};
    tbl[6] = '{8, 8, 0, 64, 3, 1, 67, 5};

    st = 1'b0; st2 = 1'b0;
    w = '0; h = '0; w2 = '0; h2 = '0;
    xi.i_DEPTH_XDS_READY = 1'b1;
    xi2.i_DEPTH_XDS_READY = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    check_reset("rst0");
    step();
    rst = 1'b0;
    step();

    foreach (tbl[i]) begin
      do_frame(tbl[i]);
      step();
    end

    // reset while pixel 20 of a 16x16 frame is due
    ffb = ff_n;
    pb = q_pix.size();
    w = 8'd16; h = 8'd16; st = 1'b1;
    step();
    st = 1'b0;
    to = 1;
    for (int i = 0; i < 200; i++) begin
      if (q_pix.size() - pb >= 20) begin
        to = 0;
        break;
      end
      step();
    end
    chk("mid_timeout", to, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset("midrst");
    step();
    step();
    chk("mid_no_ff", ff_n - ffb, 0);
    do_frame('{2, 2, 0, 4, 3, 1, 7, -1});

    // 4-bit address instance: pixel 16 wraps to mem2[0]
    pb = q_pix2.size();
    ffb = ff2_n;
    w2 = 8'd5; h2 = 8'd4; st2 = 1'b1;
    step();
    st2 = 1'b0;
    to = 1;
    for (int i = 0; i < 200; i++) begin
      if (!busy2) begin
        to = 0;
        break;
      end
      step();
    end
    chk("wrap_timeout", to, 0);
    chk("wrap_npix", q_pix2.size() - pb, 20);
    chk("wrap_ff_n", ff2_n - ffb, 1);
    for (int k = 0; k < 20; k++) begin
      if (pb + k < q_pix2.size())
        chk($sformatf("wrap_pix%0d", k),
            q_pix2[pb + k], 8'h80 | (k % 16));
    end

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
